// File: rtl/audio_serial_pkg.sv
// Shared definitions for the 3-wire audio serial bus (DAC writer and ADC reader).
package audio_serial_pkg;

  localparam int unsigned CLK_DIV_DEF   = 4;
  localparam int unsigned AUDIO_DATA_W  = 16;
  localparam int unsigned AUDIO_FRAME_W = 24;

  // Power-down mode field carried in every DAC frame
  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_TRI    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_END   = 2'd2,
    ST_GAP   = 2'd3
  } serial_state_e;

endpackage

// File: rtl/serial_tick_div.sv
// Free-running divider producing a one-clk tick every DIV clocks (DIV >= 2).
module serial_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic resetn_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == LAST) cnt_d = '0;
  end

  // tick_q is registered from the next count so it is high exactly while cnt_q == LAST
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/audio_dac_write.sv
// Serial DAC writer: one-entry sample buffer feeding a 24-bit MSB-first cs/sclk/sdin frame.
module audio_dac_write
  import audio_serial_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DATA_W  = AUDIO_DATA_W,
  parameter int unsigned FRAME_W = AUDIO_FRAME_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_pd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cs,
  output logic              sclk,
  output logic              sdin,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
  localparam int unsigned PAD_W = FRAME_W - DATA_W - 2;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W);

  serial_state_e      state_q;
  logic [FRAME_W-1:0] buf_q;
  logic               in_ready_q;
  logic [FRAME_W-2:0] shreg_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               cs_q;
  logic               sclk_q;
  logic               sdin_q;
  logic               busy_q;
  logic               done_q;
  logic               tick;
  logic               accept;

  serial_tick_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk_i    (clk),
    .resetn_i (resetn),
    .tick_o   (tick)
  );

  assign accept = in_valid & in_ready_q;

  // Handshake runs every clk; bus state advances only on ticks.
  // Accept and load cannot coincide: accept needs an empty buffer, load a full one.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      in_ready_q <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b1;
      sdin_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        buf_q      <= {{PAD_W{1'b0}}, in_pd, in_data};
        in_ready_q <= 1'b0;
      end

      if (tick) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!in_ready_q) begin
              shreg_q    <= buf_q[FRAME_W-2:0];
              in_ready_q <= 1'b1;
              cs_q       <= 1'b0;
              sclk_q     <= 1'b1;
              sdin_q     <= buf_q[FRAME_W-1];
              bit_cnt_q  <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (sclk_q) begin
              sclk_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end else if (bit_cnt_q < LAST_BIT) begin
              sclk_q  <= 1'b1;
              sdin_q  <= shreg_q[FRAME_W-2];
              shreg_q <= {shreg_q[FRAME_W-3:0], 1'b0};
            end else begin
              sclk_q  <= 1'b1;
              sdin_q  <= 1'b0;
              state_q <= ST_END;
            end
          end
          ST_END: begin
            cs_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= ST_GAP;
          end
          ST_GAP: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready = in_ready_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign sdin     = sdin_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_audio_dac_write.sv
// Bench for audio_dac_write: a bus-side decoder rebuilds each frame and is compared to a queue model.
module tb_audio_dac_write;
  import audio_serial_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_pd = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, cs, sclk, sdin, busy, done;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  audio_dac_write dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_pd    (in_pd),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cs       (cs),
    .sclk     (sclk),
    .sdin     (sdin),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the DAC side: latch sdin on each sclk fall while cs is low
  logic        cs_p = 1'b1, sclk_p = 1'b1, busy_p = 1'b0;
  logic [23:0] sh = '0;
  int nb = 0, fall_cyc = 0, busy_fall_cyc = 0, sclk_edges = 0;
  int cs_falls = 0, done_cnt = 0, aborted = 0, frames_seen = 0;
  logic [23:0] got_frame_q[$];
  int          got_bits_q[$];
  int          got_low_q[$];
  int          got_rise_q[$];
  logic        got_done_q[$];
  logic [23:0] exp_q[$];

  always @(negedge clk) begin
    cs_p   <= cs;
    sclk_p <= sclk;
    busy_p <= busy;
    if (sclk !== sclk_p) sclk_edges <= sclk_edges + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy_p === 1'b1 && busy === 1'b0) busy_fall_cyc <= cyc;
    if (cs_p === 1'b1 && cs === 1'b0) begin
      sh       <= '0;
      nb       <= 0;
      fall_cyc <= cyc;
      cs_falls <= cs_falls + 1;
    end else if (cs === 1'b0 && sclk_p === 1'b1 && sclk === 1'b0) begin
      sh <= {sh[22:0], sdin};
      nb <= nb + 1;
    end
    if (cs_p === 1'b0 && cs === 1'b1) begin
      if (resetn === 1'b0) begin
        aborted <= aborted + 1;
      end else begin
        got_frame_q.push_back(sh);
        got_bits_q.push_back(nb);
        got_low_q.push_back(cyc - fall_cyc);
        got_rise_q.push_back(cyc);
        got_done_q.push_back(done);
        frames_seen <= frames_seen + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] p, input bit keep);
    int t;
    t = 0;
    in_data  = d;
    in_pd    = p;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 1000) begin
      step();
      t++;
    end
    check("send accepted", 32'(in_ready === 1'b1), 32'd1);
    step();
    exp_q.push_back((24'(p) << 16) | 24'(d));
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (got_frame_q.size() < n && t < 2000) begin
      step();
      t++;
    end
    check("frames arrived", 32'(got_frame_q.size() >= n), 32'd1);
  endtask

  int last_rise = 0;

  task automatic cmp_frame(input string tag);
    logic [23:0] g, e;
    check({tag, " present"}, 32'(got_frame_q.size() > 0 && exp_q.size() > 0), 32'd1);
    if (got_frame_q.size() > 0 && exp_q.size() > 0) begin
      g = got_frame_q.pop_front();
      e = exp_q.pop_front();
      check({tag, " data"}, 32'(g), 32'(e));
      check({tag, " bits"}, 32'(got_bits_q.pop_front()), 32'd24);
      check({tag, " cs low clk"}, 32'(got_low_q.pop_front()), 32'd196);
      check({tag, " done at cs rise"}, 32'(got_done_q.pop_front()), 32'd1);
      last_rise = got_rise_q.pop_front();
    end
  endtask

  initial begin
    int t, r0, e0, f0, d0;
    logic [15:0] rd;
    logic [1:0]  rp;

    // Reset values
    steps(3);
    check("rst cs", 32'(cs), 32'd1);
    check("rst sclk", 32'(sclk), 32'd1);
    check("rst sdin", 32'(sdin), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    steps(2);

    // Single write
    send(16'hA5C3, PD_NORMAL, 1'b0);
    wait_frames(1);
    cmp_frame("single");
    steps(8);
    check("single busy drop", 32'(busy_fall_cyc - last_rise), 32'd4);
    check("single done count", 32'(done_cnt), 32'd1);

    // Back-to-back with in_valid held
    send(16'h0001, PD_NORMAL, 1'b1);
    send(16'hFFFF, PD_NORMAL, 1'b0);
    check("b2b accepted mid-frame", 32'(busy), 32'd1);
    wait_frames(2);
    cmp_frame("b2b first");
    r0 = last_rise;
    cmp_frame("b2b second");
    check("b2b period", 32'(last_rise - r0), 32'd204);

    // Power-down mode field
    steps(20);
    send(16'h0000, PD_TRI, 1'b0);
    wait_frames(1);
    cmp_frame("powerdown");

    // Backpressure: frame active and buffer full
    steps(20);
    send(16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    send(16'($urandom), 2'($urandom_range(0, 3)), 1'b0);
    in_data  = 16'h1234;
    rp       = 2'($urandom_range(0, 3));
    in_pd    = rp;
    in_valid = 1'b1;
    check("bp ready low", 32'(in_ready), 32'd0);
    check("bp busy", 32'(busy), 32'd1);
    t = 0;
    while (in_ready !== 1'b1 && t < 1000) begin
      step();
      t++;
    end
    check("bp accept after load", 32'(cyc - fall_cyc), 32'd0);
    check("bp next frame started", 32'(cs), 32'd0);
    step();
    exp_q.push_back((24'(rp) << 16) | 24'h001234);
    in_valid = 1'b0;
    wait_frames(3);
    cmp_frame("bp A");
    cmp_frame("bp B");
    cmp_frame("bp C");

    // Randomized samples with random idle gaps
    for (int i = 0; i < 6; i++) begin
      rd = 16'($urandom);
      rp = 2'($urandom_range(0, 3));
      send(rd, rp, 1'b0);
      steps($urandom_range(0, 250));
    end
    wait_frames(6);
    for (int i = 0; i < 6; i++) cmp_frame("random");

    // Reset mid-frame with a sample still buffered
    steps(20);
    send(16'h5A5A, PD_1K, 1'b0);
    send(16'hC0DE, PD_100K, 1'b0);
    steps(80);
    d0 = done_cnt;
    check("mid-frame cs low", 32'(cs), 32'd0);
    resetn = 1'b0;
    step();
    check("abort cs", 32'(cs), 32'd1);
    check("abort sclk", 32'(sclk), 32'd1);
    check("abort sdin", 32'(sdin), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    resetn = 1'b1;
    exp_q.delete();
    steps(300);
    check("abort no frame", 32'(got_frame_q.size()), 32'd0);
    check("abort count", 32'(aborted), 32'd1);
    check("abort no done", 32'(done_cnt), 32'(d0));
    send(16'hBEEF, PD_NORMAL, 1'b0);
    wait_frames(1);
    cmp_frame("after reset");

    // Underrun: idle bus stays quiet
    steps(10);
    e0 = sclk_edges;
    f0 = cs_falls;
    d0 = done_cnt;
    steps(500);
    check("underrun sclk edges", 32'(sclk_edges - e0), 32'd0);
    check("underrun cs falls", 32'(cs_falls - f0), 32'd0);
    check("underrun done", 32'(done_cnt - d0), 32'd0);
    check("underrun cs", 32'(cs), 32'd1);
    check("underrun sclk", 32'(sclk), 32'd1);
    check("total done pulses", 32'(done_cnt), 32'(frames_seen));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
